// File: rtl/decim_pkg.sv
// Shared constants and helpers for the decimating sample buffer.
// Lane helpers keep the channel-0-in-LSBs packing in one place.
package decim_pkg;

  localparam int MAX_DECIM_LOG2_DEFAULT = 4;
  localparam int DROP_CNT_W             = 16;

  typedef enum logic {
    MODE_PICK = 1'b0,
    MODE_AVG  = 1'b1
  } decim_mode_e;

  // Requested exponents beyond the supported maximum saturate rather than wrap.
  function automatic int unsigned clamp_log2(int unsigned req, int unsigned max_log2);
    return (req > max_log2) ? max_log2 : req;
  endfunction

  // Bit offset of a channel lane inside a packed multi-channel word.
  function automatic int lane_lsb(int ch, int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/decim_sample_buffer_if.sv
// Sample-in / decimated-word-out stream bundle of the decimating sample buffer.
// The master side is the ADC/DSP environment, the slave side is the buffer.
interface decim_sample_buffer_if #(
  parameter int DATA_WIDTH = 12,
  parameter int NUM_CH     = 2
);

  logic [NUM_CH*DATA_WIDTH-1:0] din;
  logic                         din_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] dout;
  logic                         dout_valid;
  logic                         dout_ready;

  modport master (
    output din, din_valid, dout_ready,
    input  dout, dout_valid
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output dout, dout_valid
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock show-ahead FIFO: the head entry is visible on rdata_o while valid_o is high.
// A push into a full FIFO is honoured only when a pop happens on the same edge.
module sync_fifo_fwft #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         valid_o,
  output logic                         full_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;

  // NOTE: storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/decim_sample_buffer.sv
// Multi-channel 2^d decimator (pick or mean) with a startup busy window,
// a one-word stage register and a show-ahead output FIFO with drop accounting.
module decim_sample_buffer
  import decim_pkg::*;
#(
  parameter int DATA_WIDTH     = 12,
  parameter int NUM_CH         = 2,
  parameter int LOG2_DECIM_MAX = MAX_DECIM_LOG2_DEFAULT,
  parameter int FIFO_DEPTH     = 16,
  parameter int BUSY_CYCLES    = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [$clog2(LOG2_DECIM_MAX+1)-1:0] decim_log2,
  input  logic                                avg_mode,
  output logic                                in_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
  output logic                                overflow,
  output logic [DROP_CNT_W-1:0]               drop_cnt,
  decim_sample_buffer_if.slave                bus
);

  localparam int DL_W   = $clog2(LOG2_DECIM_MAX+1);
  localparam int ACC_W  = DATA_WIDTH + LOG2_DECIM_MAX;
  localparam int WORD_W = NUM_CH * DATA_WIDTH;
  localparam int SC_W   = (LOG2_DECIM_MAX > 0) ? LOG2_DECIM_MAX : 1;
  localparam int BUSY_W = $clog2(BUSY_CYCLES+2);

  logic [BUSY_W-1:0]     busy_cnt_q;
  logic                  accept;
  logic [SC_W-1:0]       samp_cnt_q, samp_cnt_d;
  logic [SC_W:0]         win_max;
  logic [DL_W-1:0]       d_q, d_eff;
  decim_mode_e           mode_q, mode_eff;
  logic                  first, last;
  logic [WORD_W-1:0]     result;
  logic                  stage_valid_q;
  logic [WORD_W-1:0]     stage_data_q;
  logic                  fifo_full, push, pop, drop;
  logic                  overflow_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  assign in_busy = (busy_cnt_q != BUSY_W'(BUSY_CYCLES));
  assign accept  = bus.din_valid && !in_busy;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          busy_cnt_q <= '0;
    else if (in_busy) busy_cnt_q <= busy_cnt_q + BUSY_W'(1);
  end

  // Rate and mode come live from the ports on a window's first sample, then from the latches.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    first      = (samp_cnt_q == '0);
    d_eff      = first ? DL_W'(clamp_log2(32'(decim_log2), 32'(LOG2_DECIM_MAX))) : d_q;
    mode_eff   = first ? decim_mode_e'(avg_mode) : mode_q;
    win_max    = ((SC_W+1)'(1) << d_eff) - (SC_W+1)'(1);
    last       = ({1'b0, samp_cnt_q} == win_max);
    samp_cnt_d = samp_cnt_q;
    if (accept) samp_cnt_d = last ? '0 : samp_cnt_q + SC_W'(1);
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    localparam int LSB = lane_lsb(ch, DATA_WIDTH);
    logic signed [DATA_WIDTH-1:0] sample;
    logic signed [ACC_W-1:0]      acc_q, acc_d;

    assign sample = bus.din[LSB +: DATA_WIDTH];
    assign acc_d  = first ? ACC_W'(sample) : acc_q + ACC_W'(sample);
    // Arithmetic shift floors the mean; the low DATA_WIDTH bits always hold it.
    assign result[LSB +: DATA_WIDTH] =
      (mode_eff == MODE_AVG) ? DATA_WIDTH'(acc_d >>> d_eff) : sample;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)         acc_q <= '0;
      else if (accept) acc_q <= acc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_cnt_q    <= '0;
      d_q           <= '0;
      mode_q        <= MODE_PICK;
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
    end else begin
      samp_cnt_q <= samp_cnt_d;
      if (accept && first) begin
        d_q    <= d_eff;
        mode_q <= mode_eff;
      end
      stage_valid_q <= accept && last;
      if (accept && last) stage_data_q <= result;
    end
  end

  // The stage register never stalls: a word that finds the FIFO full and not draining is lost.
  assign pop  = bus.dout_valid && bus.dout_ready;
  assign push = stage_valid_q && (!fifo_full || pop);
  assign drop = stage_valid_q && fifo_full && !pop;

  sync_fifo_fwft #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (stage_data_q),
    .pop_i   (pop),
    .rdata_o (bus.dout),
    .valid_o (bus.dout_valid),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_decim_sample_buffer.sv
// Scoreboard bench for decim_sample_buffer: stimulus queues expected words,
// a negedge monitor compares every word the DUT hands over.
module tb_decim_sample_buffer;

  localparam int DW    = 12;
  localparam int NCH   = 2;
  localparam int DEPTH = 16;
  localparam int BUSY  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  decim_log2 = '0;
  logic        avg_mode = 1'b0;
  logic        in_busy;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [15:0] drop_cnt;

  decim_sample_buffer_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

  decim_sample_buffer #(
    .DATA_WIDTH     (DW),
    .NUM_CH         (NCH),
    .LOG2_DECIM_MAX (4),
    .FIFO_DEPTH     (DEPTH),
    .BUSY_CYCLES    (BUSY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .decim_log2 (decim_log2),
    .avg_mode   (avg_mode),
    .in_busy    (in_busy),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q [$];

  function automatic logic [23:0] w(int a, int b);
    logic [11:0] la, lb;
    la = 12'(a);
    lb = 12'(b);
    return {lb, la};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int a, int b);
    bus.din       = w(a, b);
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
  endtask

  task automatic drain();
    bus.dout_ready = 1'b1;
    for (int n = 0; n < 64 && bus.dout_valid; n++) tick();
    bus.dout_ready = 1'b0;
    check("drain_empty", 32'(bus.dout_valid), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every accepted output word is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.dout_valid && bus.dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dout_unexpected: got %0h expected none", bus.dout);
      end else begin
        check("dout", 32'(bus.dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.din        = '0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("rst_in_busy",    32'(in_busy),        32'd1);
    check("rst_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("rst_dout",       32'(bus.dout),       32'd0);
    check("rst_fifo_count", 32'(fifo_count),     32'd0);
    check("rst_overflow",   32'(overflow),       32'd0);
    check("rst_drop_cnt",   32'(drop_cnt),       32'd0);

    // Busy window with din_valid held high: busy samples must be ignored.
    decim_log2    = 3'd2;
    avg_mode      = 1'b0;
    bus.din_valid = 1'b1;
    bus.din       = w(100, 100);
    rst           = 1'b0;
    for (int k = 1; k <= BUSY; k++) begin
      bus.din = w(100 + k, 100 + k);
      tick();
      check("busy_window", 32'(in_busy), (k < BUSY) ? 32'd1 : 32'd0);
    end
    send(1, 10);
    send(2, 20);
    send(3, 30);
    exp_q.push_back(w(4, 40));
    send(4, 40);
    check("busy_first_valid_early", 32'(bus.dout_valid), 32'd0);
    check("busy_first_count_early", 32'(fifo_count),     32'd0);
    tick();
    check("busy_first_valid", 32'(bus.dout_valid), 32'd1);
    check("busy_first_count", 32'(fifo_count),     32'd1);
    drain();

    // Pick mode d=2 ramp, with latency probe on the first window.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(w(3, -3));
      send(i, -i);
    end
    check("lat_after_E", 32'(bus.dout_valid), 32'd0);
    @(negedge clk);
    check("lat_mid", 32'(bus.dout_valid), 32'd0);
    tick();
    check("lat_after_E1", 32'(bus.dout_valid), 32'd1);
    for (int i = 4; i < 12; i++) begin
      if (i == 7 || i == 11) exp_q.push_back(w(i, -i));
      send(i, -i);
    end
    tick();
    check("pick_count", 32'(fifo_count), 32'd3);
    drain();

    // Average mode d=2: floor of negative mean, full-scale lanes, second window.
    avg_mode = 1'b1;
    exp_q.push_back(w(-2, 2047));
    send(-1, 2047);
    send(-2, 2047);
    send(-2, 2047);
    send(-2, 2047);
    exp_q.push_back(w(1, -2048));
    send(1, -2048);
    send(2, -2048);
    send(2, -2048);
    send(2, -2048);
    tick();
    check("avg_count", 32'(fifo_count), 32'd2);
    drain();

    // Exponent 7 clamps to 4: one 16-sample window.
    decim_log2 = 3'd7;
    avg_mode   = 1'b0;
    exp_q.push_back(w(215, -215));
    for (int i = 0; i < 16; i++) send(200 + i, -200 - i);
    tick();
    check("clamp_count", 32'(fifo_count), 32'd1);
    drain();

    // Mid-window change of rate and mode only applies to the next window.
    decim_log2 = 3'd2;
    avg_mode   = 1'b0;
    send(300, 0);
    decim_log2 = 3'd0;
    avg_mode   = 1'b1;
    send(301, 1);
    send(302, 2);
    exp_q.push_back(w(303, 3));
    send(303, 3);
    exp_q.push_back(w(304, 4));
    send(304, 4);
    exp_q.push_back(w(305, 5));
    send(305, 5);
    tick();
    check("midchange_count", 32'(fifo_count), 32'd3);
    drain();

    // FIFO full: 20 words into 16 entries with no consumer.
    avg_mode = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i < DEPTH) exp_q.push_back(w(500 + i, i));
      send(500 + i, i);
    end
    tick();
    check("full_count",    32'(fifo_count), 32'd16);
    check("full_overflow", 32'(overflow),   32'd1);
    check("full_drop_cnt", 32'(drop_cnt),   32'd4);
    for (int j = 0; j < 2; j++) begin
      exp_q.push_back(w(600 + j, 60 + j));
      send(600 + j, 60 + j);
      bus.dout_ready = 1'b1;
      tick();
      bus.dout_ready = 1'b0;
      check("full_pushpop_count", 32'(fifo_count), 32'd16);
      check("full_pushpop_drop",  32'(drop_cnt),   32'd4);
    end
    drain();

    // Reset mid-window clears the partial window, FIFO contents and drop accounting.
    send(800, 0);
    tick();
    check("prerst_count", 32'(fifo_count), 32'd1);
    decim_log2 = 3'd2;
    send(801, 0);
    send(802, 0);
    rst = 1'b1;
    tick();
    check("midrst_in_busy",    32'(in_busy),        32'd1);
    check("midrst_count",      32'(fifo_count),     32'd0);
    check("midrst_dout_valid", 32'(bus.dout_valid), 32'd0);
    check("midrst_overflow",   32'(overflow),       32'd0);
    check("midrst_drop_cnt",   32'(drop_cnt),       32'd0);
    rst = 1'b0;
    repeat (BUSY) tick();
    check("postrst_in_busy", 32'(in_busy), 32'd0);
    exp_q.push_back(w(703, 3));
    for (int i = 0; i < 4; i++) send(700 + i, i);
    tick();
    check("postrst_count", 32'(fifo_count), 32'd1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decim_sample_buffer.md
Name: decim_sample_buffer

Overview:
- Parametrised multi-channel front-end that sits between the ADC sample path and the DSP core.
- Decimates NUM_CH channels by a runtime factor of 2^decim_log2, in either pick or average mode.
- Buffers the decimated words in an internal FIFO and presents them on a ready/valid interface.
- Successor to the fixed-rate no-downsample plus external input FIFO pair; adds rate selection, averaging, overflow accounting and a startup busy window.

Parameters:
- DATA_WIDTH, 12, signed sample width per channel.
- NUM_CH, 2, number of channels processed in lockstep.
- LOG2_DECIM_MAX, 4, maximum decimation exponent (factor up to 16).
- FIFO_DEPTH, 16, FIFO entries; power of two, at least 4.
- BUSY_CYCLES, 8, cycles in_busy stays high after reset release.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- decim_log2  in  $clog2(LOG2_DECIM_MAX+1)  decimation exponent; values above LOG2_DECIM_MAX are clamped to LOG2_DECIM_MAX.
- avg_mode  in  1  0 = pick the last sample of the window, 1 = output the window mean.
- din  in  NUM_CH*DATA_WIDTH  packed signed samples; channel 0 in the LSBs.
- din_valid  in  1  input sample strobe.
- in_busy  out  1  high during the post-reset window; input is ignored while high.
- dout  out  NUM_CH*DATA_WIDTH  head-of-FIFO word.
- dout_valid  out  1  FIFO not empty.
- dout_ready  in  1  consumer accepts the head word.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- overflow  out  1  sticky: at least one decimated word has been dropped.
- drop_cnt  out  16  saturating count of dropped words.

Behaviour:
- Reset values: all outputs 0 except in_busy = 1. Accumulators, counters, FIFO pointers, overflow and drop_cnt are cleared. Reset asserted mid-window discards the partial window and all FIFO contents.
- Busy window:
  - in_busy deasserts after exactly BUSY_CYCLES rising edges following rst deassertion.
  - din_valid is ignored while in_busy = 1.
- Acceptance: a sample is accepted on a rising edge where din_valid = 1 and in_busy = 0.
- Window control:
  - The window length L = 2^d, where d = clamped decim_log2.
  - decim_log2 and avg_mode are latched at the first accepted sample of each window. Changes mid-window take effect at the next window.
  - A sample counter runs 0..L-1 and wraps to 0 after the last sample.
- Accumulator:
  - Per channel, width DATA_WIDTH + LOG2_DECIM_MAX, with sign extension.
  - On the first sample of a window the accumulator loads the sample; on later samples it adds the sample.
- Result on the last sample of a window:
  - avg_mode = 0: the last accepted sample.
  - avg_mode = 1: the sum arithmetically right-shifted by d, i.e. truncated toward minus infinity, taking the low DATA_WIDTH bits. The shifted result always fits in DATA_WIDTH.
  - d = 0: every accepted sample passes through unchanged in both modes.
- Stage register: the result is registered in a stage register (stage_valid) on the window's last-sample edge E, and written to the FIFO on edge E+1.
- Latency: with the FIFO empty, dout_valid rises after edge E+1, i.e. 2 clocks after the final sample is accepted.
- FIFO:
  - Show-ahead: dout always equals the head entry whenever dout_valid = 1.
  - Pop happens on an edge where dout_valid && dout_ready.
  - Push happens when stage_valid && (count < FIFO_DEPTH || pop).
  - Simultaneous push and pop leaves the count unchanged, including when full.
  - Pop while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow:
  - Occurs when stage_valid, the FIFO is full and there is no pop.
  - The word is dropped, overflow is set, and drop_cnt increments, saturating at 16'hFFFF.
  - Both overflow and drop_cnt are cleared only by rst.
- Stage register never stalls: a new window result overwrites the stage register every completed window. There is no backpressure to din.

Decomposition:
- Shared package decim_pkg:
  - constants MAX_DECIM_LOG2_DEFAULT and DROP_CNT_W = 16;
  - function clamp_log2;
  - function to pack/unpack channel lanes.
- One sub-module: sync_fifo_fwft, a single-clock show-ahead FIFO with parameters WIDTH and DEPTH.
- Decimation datapath (per-channel accumulators, generated with a loop) and the busy counter live in the top module.

Test Plan:
- Reset/busy: BUSY_CYCLES = 8, din_valid held at 1 from reset release.
  - Required: in_busy drops after 8 edges, no samples counted before that, first dout appears only after 2^d post-busy samples.
- Pick mode, d = 2, channel 0 ramp 0,1,2,...:
  - Required: dout ch0 = 3, 7, 11; first dout_valid 2 clocks after sample 3 is accepted.
- Average mode, d = 2, samples -1, -2, -2, -2:
  - Required: sum = -7, output = -2 (floor).
  - Also: samples 2047 ×4 → 2047 with no overflow of the lane.
- Clamp and mid-window change:
  - decim_log2 = 7 with LOG2_DECIM_MAX = 4 → window of 16.
  - Changing d from 2 to 0 after 1 sample → current window still 4 samples long, then 1-sample windows.
- FIFO full:
  - d = 0, dout_ready = 0, 20 samples, depth 16 → fifo_count = 16, overflow = 1, drop_cnt = 4.
  - Then dout_ready = 1 → outputs are the first 16 samples in order.
- Full with simultaneous pop and push: count stays 16, no drop, data order preserved. Assert rst mid-window → all state cleared, in_busy = 1.
